// File: rtl/scratch_access_ctrl.sv
// scratch_access_ctrl: sequencer between the control unit and the 256x10 scratch RAM.
// It accepts one memory or stack request at a time and owns the stack pointer.
// Each request runs IDLE -> EXEC -> FIN -> IDLE, with DONE pulsing in FIN.
// Optional macro SCR_STACK_GUARD_EN adds sticky overflow/underflow flags.
// With the guard, PUSH/CALL at STACK_LIMIT and POP at SP==0 are blocked.
module scratch_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 10,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic [2:0]        OP,
  input  logic [7:0]        REG_DATA,
  input  logic [7:0]        REG_ADDR,
  input  logic [7:0]        IMM_ADDR,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] SCR_RD_DATA,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0] SCR_DATA_IN,
  output logic              SCR_WE,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              BUSY,
  output logic              DONE,
`ifdef SCR_STACK_GUARD_EN
  output logic              STK_OVF,
  output logic              STK_UNF,
`endif
  output logic [ADDR_W-1:0] SP
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [2:0] OP_WSP  = 3'd0;
  localparam logic [2:0] OP_ST_R = 3'd1;
  localparam logic [2:0] OP_ST_I = 3'd2;
  localparam logic [2:0] OP_LD_R = 3'd3;
  localparam logic [2:0] OP_LD_I = 3'd4;
  localparam logic [2:0] OP_PUSH = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_CALL = 3'd7;

  logic [1:0]        state_q;
  logic [2:0]        op_q;
  logic [7:0]        reg_data_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] scr_addr_q;
  logic [DATA_W-1:0] scr_data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              we_q;
  logic              push_full;
  logic              pop_empty;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_access;
  logic              req_we;

`ifdef SCR_STACK_GUARD_EN
  logic ovf_q;
  logic unf_q;
  assign push_full = (sp_q == STACK_LIMIT);
  assign pop_empty = (sp_q == '0);
  assign STK_OVF   = ovf_q;
  assign STK_UNF   = unf_q;
`else
  assign push_full = 1'b0;
  assign pop_empty = 1'b0;
`endif

  // Work out the RAM address, write data and write intent of an incoming request;
  // SP cannot move between acceptance and EXEC, so stack addresses are final here.
  always_comb begin
    req_addr   = scr_addr_q;
    req_data   = scr_data_q;
    req_access = 1'b1;
    req_we     = 1'b0;
    case (OP)
      OP_WSP:  req_access = 1'b0;
      OP_ST_R: begin req_addr = ADDR_W'(REG_ADDR); req_data = DATA_W'(REG_DATA); req_we = 1'b1; end
      OP_ST_I: begin req_addr = ADDR_W'(IMM_ADDR); req_data = DATA_W'(REG_DATA); req_we = 1'b1; end
      OP_LD_R: req_addr = ADDR_W'(REG_ADDR);
      OP_LD_I: req_addr = ADDR_W'(IMM_ADDR);
      OP_PUSH: begin req_addr = sp_q - ADDR_W'(1); req_data = DATA_W'(REG_DATA); req_we = ~push_full; end
      OP_CALL: begin req_addr = sp_q - ADDR_W'(1); req_data = PC; req_we = ~push_full; end
      OP_POP:  req_addr = sp_q;
      default: req_access = 1'b0;
    endcase
  end

  // Request sequencing, SP update and read-data capture; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WSP;
      reg_data_q <= '0;
      sp_q       <= '0;
      scr_addr_q <= '0;
      scr_data_q <= '0;
      rd_data_q  <= '0;
      we_q       <= 1'b0;
`ifdef SCR_STACK_GUARD_EN
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            state_q    <= ST_EXEC;
            op_q       <= OP;
            reg_data_q <= REG_DATA;
            we_q       <= req_we;
            if (req_access) scr_addr_q <= req_addr;
            if (req_we)     scr_data_q <= req_data;
          end
        end
        ST_EXEC: begin
          state_q <= ST_FIN;
          we_q    <= 1'b0;
          case (op_q)
            OP_WSP:           sp_q <= ADDR_W'(reg_data_q);
            OP_LD_R, OP_LD_I: rd_data_q <= SCR_RD_DATA;
            OP_PUSH, OP_CALL: begin
              if (!push_full) sp_q <= sp_q - ADDR_W'(1);
`ifdef SCR_STACK_GUARD_EN
              else ovf_q <= 1'b1;
`endif
            end
            OP_POP: begin
              if (!pop_empty) begin
                sp_q      <= sp_q + ADDR_W'(1);
                rd_data_q <= SCR_RD_DATA;
              end else begin
                rd_data_q <= '0;
`ifdef SCR_STACK_GUARD_EN
                unf_q     <= 1'b1;
`endif
              end
            end
            default: ;
          endcase
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The write strobe is gated by reset so a reset edge can never commit a write.
  assign SCR_WE      = (state_q == ST_EXEC) & we_q & ~RST;
  assign SCR_ADDR    = scr_addr_q;
  assign SCR_DATA_IN = scr_data_q;
  assign RD_DATA     = rd_data_q;
  assign SP          = sp_q;
  assign BUSY        = (state_q == ST_EXEC) | (state_q == ST_FIN);
  assign DONE        = (state_q == ST_FIN);
  assign RD_VALID    = (state_q == ST_FIN) &
                       ((op_q == OP_LD_R) | (op_q == OP_LD_I) | (op_q == OP_POP));

endmodule

// File: tb/tb_scratch_access_ctrl.sv
// tb_scratch_access_ctrl: directed and random checks of scratch_access_ctrl.
// The bench holds a behavioural RAM and a reference model of memory and stack.
// Define SCR_STACK_GUARD_EN to exercise the stack guard build.
module tb_scratch_access_ctrl;

  localparam logic [2:0] WSP = 3'd0, ST_R = 3'd1, ST_I = 3'd2, LD_R = 3'd3;
  localparam logic [2:0] LD_I = 3'd4, PUSH = 3'd5, POP = 3'd6, CALL = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] op;
  logic [7:0] reg_data, reg_addr, imm_addr;
  logic [9:0] pc;
  logic [9:0] scr_rd_data;
  logic [7:0] scr_addr;
  logic [9:0] scr_data_in;
  logic       scr_we;
  logic [9:0] rd_data;
  logic       rd_valid, busy, done;
  logic [7:0] sp;
`ifdef SCR_STACK_GUARD_EN
  logic       stk_ovf, stk_unf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] ram     [256];
  logic [9:0] m_mem   [256];
  logic [7:0] m_sp;
  logic [9:0] m_rd;
  logic [7:0] m_addr;
  logic [9:0] m_data;
  logic       m_addr_known;
`ifdef SCR_STACK_GUARD_EN
  logic       m_ovf, m_unf;
`endif

  scratch_access_ctrl dut (
    .CLK(clk), .RST(rst), .REQ(req), .OP(op),
    .REG_DATA(reg_data), .REG_ADDR(reg_addr), .IMM_ADDR(imm_addr), .PC(pc),
    .SCR_RD_DATA(scr_rd_data), .SCR_ADDR(scr_addr), .SCR_DATA_IN(scr_data_in),
    .SCR_WE(scr_we), .RD_DATA(rd_data), .RD_VALID(rd_valid), .BUSY(busy), .DONE(done),
`ifdef SCR_STACK_GUARD_EN
    .STK_OVF(stk_ovf), .STK_UNF(stk_unf),
`endif
    .SP(sp)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Behavioural scratch RAM: combinational read, clocked write
  assign scr_rd_data = ram[scr_addr];
  always @(posedge clk) if (scr_we) ram[scr_addr] <= scr_data_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic resetModel();
    m_sp = 8'h00; m_rd = 10'h000; m_addr = 8'h00; m_data = 10'h000; m_addr_known = 1'b1;
`ifdef SCR_STACK_GUARD_EN
    m_ovf = 1'b0; m_unf = 1'b0;
`endif
  endtask

  // One complete request, with expectations derived from the operation's rules
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] rd, input logic [7:0] ra,
                               input logic [7:0] ia, input logic [9:0] p);
    logic [7:0] a;
    logic [9:0] d;
    logic       acc, we, rdop, blocked;
    a = m_addr; d = m_data; acc = 1'b1; we = 1'b0; rdop = 1'b0; blocked = 1'b0;
    case (o)
      WSP:  acc = 1'b0;
      ST_R: begin a = ra; d = {2'b00, rd}; we = 1'b1; end
      ST_I: begin a = ia; d = {2'b00, rd}; we = 1'b1; end
      LD_R: begin a = ra; rdop = 1'b1; end
      LD_I: begin a = ia; rdop = 1'b1; end
      PUSH: begin a = 8'(m_sp - 8'd1); d = {2'b00, rd}; we = 1'b1; end
      CALL: begin a = 8'(m_sp - 8'd1); d = p; we = 1'b1; end
      default: begin a = m_sp; rdop = 1'b1; end
    endcase
`ifdef SCR_STACK_GUARD_EN
    if ((o == PUSH || o == CALL) && m_sp == 8'hC0) begin blocked = 1'b1; we = 1'b0; end
    if (o == POP && m_sp == 8'h00) blocked = 1'b1;
`endif
    req = 1'b1; op = o; reg_data = rd; reg_addr = ra; imm_addr = ia; pc = p;
    @(negedge clk);
    req = 1'b0; op = 3'($urandom_range(0, 7)); reg_data = 8'($urandom);
    checkOutput("exec_busy", busy, 1'b1);
    checkOutput("exec_done", done, 1'b0);
    checkOutput("exec_we", scr_we, we);
    if (acc && !blocked) checkOutput("exec_addr", scr_addr, a);
    if (we) checkOutput("exec_wdata", scr_data_in, d);
    if (acc) begin m_addr = a; m_addr_known = !blocked; end
    if (we) begin m_data = d; m_mem[a] = d; end
    if (rdop) m_rd = blocked ? 10'h000 : m_mem[a];
    if (!blocked) begin
      if (o == WSP) m_sp = rd;
      else if (o == PUSH || o == CALL) m_sp = 8'(m_sp - 8'd1);
      else if (o == POP) m_sp = 8'(m_sp + 8'd1);
    end
`ifdef SCR_STACK_GUARD_EN
    if (blocked && o == POP) m_unf = 1'b1;
    else if (blocked) m_ovf = 1'b1;
`endif
    @(negedge clk);
    checkOutput("fin_done", done, 1'b1);
    checkOutput("fin_valid", rd_valid, rdop);
    checkOutput("fin_rd_data", rd_data, m_rd);
    checkOutput("fin_sp", sp, m_sp);
    if (we) checkOutput("ram_word", ram[a], m_mem[a]);
`ifdef SCR_STACK_GUARD_EN
    checkOutput("stk_ovf", stk_ovf, m_ovf);
    checkOutput("stk_unf", stk_unf, m_unf);
`endif
    @(negedge clk);
    checkOutput("idle_done", done, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_we", scr_we, 1'b0);
    if (m_addr_known) checkOutput("idle_addr_hold", scr_addr, m_addr);
  endtask

  task automatic doReset();
    rst = 1'b1; req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    resetModel();
    checkOutput("rst_sp", sp, 8'h00);
    checkOutput("rst_rd_data", rd_data, 10'h000);
    checkOutput("rst_addr", scr_addr, 8'h00);
    checkOutput("rst_wdata", scr_data_in, 10'h000);
    checkOutput("rst_flags", {scr_we, rd_valid, busy, done}, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = WSP; reg_data = 8'h00; reg_addr = 8'h00; imm_addr = 8'h00; pc = 10'h000;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 10'($urandom);
      m_mem[i] = ram[i];
    end
    doReset();

    // Store then load through the immediate address
    applyStimulus(ST_I, 8'hA5, 8'h00, 8'h10, 10'h000);
    applyStimulus(LD_I, 8'h00, 8'h00, 8'h10, 10'h000);
    checkOutput("t1_ld", rd_data, 10'h0A5);

    // Two pushes from an empty stack, then two pops
    applyStimulus(PUSH, 8'h11, 8'h00, 8'h00, 10'h000);
    applyStimulus(PUSH, 8'h22, 8'h00, 8'h00, 10'h000);
    checkOutput("t2_ram_ff", ram[8'hFF], 10'h011);
    checkOutput("t2_ram_fe", ram[8'hFE], 10'h022);
    checkOutput("t2_sp", sp, 8'hFE);
    applyStimulus(POP, 8'h00, 8'h00, 8'h00, 10'h000);
    checkOutput("t2_pop1", rd_data, 10'h022);
    applyStimulus(POP, 8'h00, 8'h00, 8'h00, 10'h000);
    checkOutput("t2_pop2", rd_data, 10'h011);
    checkOutput("t2_sp_end", sp, 8'h00);

    // CALL keeps the full 10-bit return address
    applyStimulus(WSP, 8'h40, 8'h00, 8'h00, 10'h000);
    applyStimulus(CALL, 8'h00, 8'h00, 8'h00, 10'h3FF);
    applyStimulus(POP, 8'h00, 8'h00, 8'h00, 10'h000);
    checkOutput("t3_ret", rd_data, 10'h3FF);
    checkOutput("t3_sp", sp, 8'h40);

`ifndef SCR_STACK_GUARD_EN
    // SP wraps freely in both directions
    applyStimulus(WSP, 8'h00, 8'h00, 8'h00, 10'h000);
    applyStimulus(POP, 8'h00, 8'h00, 8'h00, 10'h000);
    checkOutput("t4_pop_sp", sp, 8'h01);
    applyStimulus(WSP, 8'h00, 8'h00, 8'h00, 10'h000);
    applyStimulus(PUSH, 8'h5C, 8'h00, 8'h00, 10'h000);
    checkOutput("t4_wrap_sp", sp, 8'hFF);
    checkOutput("t4_wrap_ram", ram[8'hFF], 10'h05C);
`endif

    // REQ held through BUSY with a different OP: only the first op runs
    req = 1'b1; op = ST_I; reg_data = 8'h5A; imm_addr = 8'h20; reg_addr = 8'h00;
    @(negedge clk);
    op = PUSH; reg_data = 8'h99;
    m_mem[8'h20] = 10'h05A; m_addr = 8'h20; m_data = 10'h05A;
    @(negedge clk);
    checkOutput("t5_done", done, 1'b1);
    @(negedge clk);
    req = 1'b0;
    checkOutput("t5_idle", busy, 1'b0);
    @(negedge clk);
    checkOutput("t5_no_second", busy, 1'b0);
    checkOutput("t5_sp", sp, m_sp);
    checkOutput("t5_ram", ram[8'h20], 10'h05A);

    // Reset during EXEC of a store: no write, no DONE, SP back to 0
    req = 1'b1; op = ST_I; reg_data = 8'h77; imm_addr = 8'h30;
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    #1 checkOutput("t5_we_gated", scr_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    checkOutput("t5_rst_done", done, 1'b0);
    checkOutput("t5_rst_sp", sp, 8'h00);
    @(negedge clk);
    checkOutput("t5_rst_done2", done, 1'b0);
    checkOutput("t5_rst_ram", ram[8'h30], m_mem[8'h30]);

`ifdef SCR_STACK_GUARD_EN
    // Overflow at the limit, then underflow from an empty stack
    applyStimulus(WSP, 8'hC0, 8'h00, 8'h00, 10'h000);
    applyStimulus(PUSH, 8'h33, 8'h00, 8'h00, 10'h000);
    checkOutput("t6_sp", sp, 8'hC0);
    checkOutput("t6_ovf", stk_ovf, 1'b1);
    checkOutput("t6_ram", ram[8'hBF], m_mem[8'hBF]);
    doReset();
    applyStimulus(POP, 8'h00, 8'h00, 8'h00, 10'h000);
    checkOutput("t6_rd", rd_data, 10'h000);
    checkOutput("t6_unf", stk_unf, 1'b1);
    checkOutput("t6_sp0", sp, 8'h00);
`endif

    // Random mix of operations against the reference model
    for (int i = 0; i < 300; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom), 10'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
